// File: rtl/weight_posterior_estimator_pkg.sv
// Shared definitions for the weight posterior estimator: FSM state encoding and counter width helper.
// Optional feature macro used across the slice: BIT_FLIP_STATS_EN.
package weight_posterior_estimator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Per-bit vote counters must hold the full count N = 2**log_samples.
    function automatic int unsigned cnt_w(input int unsigned log_samples);
        return log_samples + 1;
    endfunction

endpackage

// File: rtl/weight_posterior_estimator_if.sv
// Sample-in / estimate-out handshake bundle for weight_posterior_estimator.
// flip_total (and LOG_SAMPLES, which sizes it) exist only when BIT_FLIP_STATS_EN is defined.
interface weight_posterior_estimator_if #(
    parameter int unsigned WORD_SIZE   = 8
`ifdef BIT_FLIP_STATS_EN
   ,parameter int unsigned LOG_SAMPLES = 4
`endif
);

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_sample;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] est_weight;
    logic [WORD_SIZE-1:0] est_confidence;
    logic                 busy;
`ifdef BIT_FLIP_STATS_EN
    logic [WORD_SIZE*LOG_SAMPLES-1:0] flip_total;

    modport master (
        output start, in_valid, in_sample, out_ready,
        input  in_ready, out_valid, est_weight, est_confidence, busy, flip_total
    );

    modport slave (
        input  start, in_valid, in_sample, out_ready,
        output in_ready, out_valid, est_weight, est_confidence, busy, flip_total
    );
`else
    modport master (
        output start, in_valid, in_sample, out_ready,
        input  in_ready, out_valid, est_weight, est_confidence, busy
    );

    modport slave (
        input  start, in_valid, in_sample, out_ready,
        output in_ready, out_valid, est_weight, est_confidence, busy
    );
`endif

endinterface

// File: rtl/weight_posterior_estimator_bit_vote_counter.sv
// One bit lane of the estimator: counts ones seen on this bit and flags majority/confidence.
// Minority count output exists only when BIT_FLIP_STATS_EN is defined.
module bit_vote_counter
    import weight_posterior_estimator_pkg::*;
#(
    parameter int unsigned LOG_SAMPLES = 4,
    parameter int unsigned CONF_THRESH = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic                        inc_i,
    output logic                        majority_o,
    output logic                        confident_o
`ifdef BIT_FLIP_STATS_EN
   ,output logic [cnt_w(LOG_SAMPLES)-1:0] minority_o
`endif
);

    localparam int unsigned CNT_W = cnt_w(LOG_SAMPLES);
    localparam int unsigned N     = 1 << LOG_SAMPLES;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(N / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(CONF_THRESH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] disagree;

    // Flags follow the post-update count so the top can capture them on the final sample's edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign disagree    = FULL - cnt_d;
    assign majority_o  = (cnt_d > HALF);
    assign confident_o = (cnt_d >= THR) || (disagree >= THR);

`ifdef BIT_FLIP_STATS_EN
    assign minority_o = (cnt_d < disagree) ? cnt_d : disagree;
`endif

endmodule

// File: rtl/weight_posterior_estimator.sv
// Collects N perturbed weight samples and emits a per-bit majority estimate with confidence mask.
// Defining BIT_FLIP_STATS_EN adds flip_total, the summed minority vote across all bits.
module weight_posterior_estimator
    import weight_posterior_estimator_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = 8,
    parameter int unsigned LOG_SAMPLES = 4,
    parameter int unsigned CONF_THRESH = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    weight_posterior_estimator_if.slave bus
);

    localparam int unsigned CNT_W = cnt_w(LOG_SAMPLES);
    localparam int unsigned N     = 1 << LOG_SAMPLES;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0] est_weight_q, est_weight_d;
    logic [WORD_SIZE-1:0] est_conf_q, est_conf_d;

    logic                 accum_hs;
    logic                 last_hs;
    logic                 clear_cnt;
    logic [WORD_SIZE-1:0] majority;
    logic [WORD_SIZE-1:0] confident;

`ifdef BIT_FLIP_STATS_EN
    localparam int unsigned FLIP_W = WORD_SIZE * LOG_SAMPLES;
    logic [CNT_W-1:0]  minority [WORD_SIZE];
    logic [FLIP_W-1:0] flip_sum;
    logic [FLIP_W-1:0] flip_total_q, flip_total_d;
`endif

    assign accum_hs  = (state_q == ACCUM) && bus.in_valid;
    assign last_hs   = accum_hs && (sample_cnt_q == LAST_IDX);
    assign clear_cnt = (state_q == IDLE) && bus.start;

    for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_bit
        bit_vote_counter #(
            .LOG_SAMPLES (LOG_SAMPLES),
            .CONF_THRESH (CONF_THRESH)
        ) u_vote (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (clear_cnt),
            .inc_i       (accum_hs && bus.in_sample[gi]),
            .majority_o  (majority[gi]),
            .confident_o (confident[gi])
`ifdef BIT_FLIP_STATS_EN
           ,.minority_o  (minority[gi])
`endif
        );
    end

`ifdef BIT_FLIP_STATS_EN
    always_comb begin
        flip_sum = '0;
        for (int unsigned i = 0; i < WORD_SIZE; i++) begin
            flip_sum = flip_sum + FLIP_W'(minority[i]);
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        out_valid_d  = out_valid_q;
        est_weight_d = est_weight_q;
        est_conf_d   = est_conf_q;
`ifdef BIT_FLIP_STATS_EN
        flip_total_d = flip_total_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = ACCUM;
                    sample_cnt_d = '0;
                end
            end
            ACCUM: begin
                if (accum_hs) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                end
                if (last_hs) begin
                    state_d      = DONE;
                    out_valid_d  = 1'b1;
                    est_weight_d = majority;
                    est_conf_d   = confident;
`ifdef BIT_FLIP_STATS_EN
                    flip_total_d = flip_sum;
`endif
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even on the handshake cycle.
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            out_valid_q  <= 1'b0;
            est_weight_q <= '0;
            est_conf_q   <= '0;
`ifdef BIT_FLIP_STATS_EN
            flip_total_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            out_valid_q  <= out_valid_d;
            est_weight_q <= est_weight_d;
            est_conf_q   <= est_conf_d;
`ifdef BIT_FLIP_STATS_EN
            flip_total_q <= flip_total_d;
`endif
        end
    end

    assign bus.in_ready       = (state_q == ACCUM);
    assign bus.busy           = (state_q != IDLE);
    assign bus.out_valid      = out_valid_q;
    assign bus.est_weight     = est_weight_q;
    assign bus.est_confidence = est_conf_q;
`ifdef BIT_FLIP_STATS_EN
    assign bus.flip_total     = flip_total_q;
`endif

endmodule

// File: tb/tb_weight_posterior_estimator.sv
// Directed bench for weight_posterior_estimator with a per-cycle behavioural model (N=16, threshold 14).
// flip_total is checked only when BIT_FLIP_STATS_EN is defined.
module tb_weight_posterior_estimator;

    localparam int N      = 16;
    localparam int THRESH = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    weight_posterior_estimator_if #(.WORD_SIZE(8)) bus ();

    weight_posterior_estimator #(
        .WORD_SIZE   (8),
        .LOG_SAMPLES (4),
        .CONF_THRESH (THRESH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] stim [$];

    // Model: samples collected this run plus the expected visible state.
    logic [7:0] mq [$];
    bit         m_armed = 1'b0;
    bit         m_coll  = 1'b0;
    bit         m_done  = 1'b0;
    logic [7:0] m_w     = 8'h00;
    logic [7:0] m_c     = 8'h00;
    int         m_f     = 0;
    int         hs_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_eval();
        int ones;
        m_f = 0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            foreach (mq[k]) ones += int'(mq[k][b]);
            m_w[b] = (2 * ones > N);
            m_c[b] = (ones >= THRESH) || ((N - ones) >= THRESH);
            m_f += (ones < N - ones) ? ones : (N - ones);
        end
    endfunction

    // Check the cycle's outputs, then advance the model with the inputs the DUT samples next edge.
    always @(negedge clk) begin
        if (m_armed) begin
            chk("in_ready",       bus.in_ready,       m_coll);
            chk("busy",           bus.busy,           m_coll || m_done);
            chk("out_valid",      bus.out_valid,      m_done);
            chk("est_weight",     bus.est_weight,     m_w);
            chk("est_confidence", bus.est_confidence, m_c);
`ifdef BIT_FLIP_STATS_EN
            chk("flip_total",     bus.flip_total,     m_f);
`endif
        end
        if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) hs_seen++;
        if (rst) begin
            m_armed = 1'b1;
            m_coll  = 1'b0;
            m_done  = 1'b0;
            mq.delete();
            m_w = 8'h00;
            m_c = 8'h00;
            m_f = 0;
        end else if (m_done) begin
            if (bus.out_ready) m_done = 1'b0;
        end else if (m_coll) begin
            if (bus.in_valid) begin
                mq.push_back(bus.in_sample);
                if (mq.size() == N) begin
                    m_eval();
                    m_coll = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (bus.start) begin
            m_coll = 1'b1;
            mq.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int gap_pct, input bit check_end);
        for (int k = 0; k < stim.size(); k++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                bus.in_valid = 1'b0;
                tick();
            end
            chk("ready_for_sample", bus.in_ready, 1'b1);
            bus.in_valid  = 1'b1;
            bus.in_sample = stim[k];
            tick();
        end
        bus.in_valid = 1'b0;
        if (check_end) begin
            chk("out_valid_latency", bus.out_valid, 1'b1);
            chk("in_ready_drop",     bus.in_ready,  1'b0);
        end
    endtask

    task automatic expect_result(input string tag, input logic [7:0] w, input logic [7:0] c,
                                 input int f, input bit ack);
        for (int waited = 0; waited < 20 && bus.out_valid !== 1'b1; waited++) tick();
        chk({tag, "_valid"}, bus.out_valid,      1'b1);
        chk({tag, "_w"},     bus.est_weight,     w);
        chk({tag, "_c"},     bus.est_confidence, c);
`ifdef BIT_FLIP_STATS_EN
        chk({tag, "_flip"},  bus.flip_total,     f);
`endif
        if (ack) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk({tag, "_idle"}, bus.busy, 1'b0);
        end
    endtask

    task automatic fill(input logic [7:0] a, input int na, input logic [7:0] b, input int nb);
        stim.delete();
        repeat (na) stim.push_back(a);
        repeat (nb) stim.push_back(b);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = 8'h00;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Valid samples while idle must not be accepted.
        bus.in_valid  = 1'b1;
        bus.in_sample = 8'hFF;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        chk("idle_ignore_valid", bus.busy, 1'b0);

        fill(8'hA5, 16, 8'h00, 0);
        do_start();
        feed(0, 1'b1);
        expect_result("all_a5", 8'hA5, 8'hFF, 0, 1'b1);

        stim.delete();
        for (int k = 0; k < 16; k++) stim.push_back((k % 2) ? 8'hFF : 8'h00);
        do_start();
        feed(0, 1'b1);
        expect_result("tie", 8'h00, 8'h00, 64, 1'b1);

        fill(8'h0F, 14, 8'hF0, 2);
        do_start();
        feed(0, 1'b1);
        expect_result("split14", 8'h0F, 8'hFF, 16, 1'b1);

        fill(8'h0F, 13, 8'hF0, 3);
        do_start();
        feed(0, 1'b1);
        expect_result("split13", 8'h0F, 8'h00, 24, 1'b1);

        // Consumer stalls in DONE while start is held high the whole time.
        fill(8'h96, 16, 8'h00, 0);
        do_start();
        feed(0, 1'b1);
        bus.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", bus.out_valid,  1'b1);
            chk("hold_w",     bus.est_weight, 8'h96);
            chk("hold_ready", bus.in_ready,   1'b0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("hold_exit_idle",  bus.busy,       1'b0);
        chk("hold_valid_drop", bus.out_valid,  1'b0);
        chk("hold_w_kept",     bus.est_weight, 8'h96);
        tick();
        chk("start_ignored", bus.busy, 1'b0);

        // Abort a run mid-way with reset, then a clean run.
        fill(8'hFF, 7, 8'h00, 0);
        do_start();
        feed(0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",  bus.busy,       1'b0);
        chk("abort_valid", bus.out_valid,  1'b0);
        chk("abort_w",     bus.est_weight, 8'h00);
        tick();
        fill(8'h3C, 16, 8'h00, 0);
        do_start();
        feed(0, 1'b1);
        expect_result("after_abort", 8'h3C, 8'hFF, 0, 1'b1);

        // Random samples with roughly half the cycles idle on in_valid.
        stim.delete();
        for (int k = 0; k < 16; k++) stim.push_back(8'($urandom));
        hs_seen = 0;
        do_start();
        feed(50, 1'b1);
        chk("gap_handshakes", hs_seen, 16);
        expect_result("gaps", m_w, m_c, m_f, 1'b1);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
